// File: rtl/dot_seq.sv
// rtl/dot_seq.sv - signed dot-product sequencer driving a shared 2x2 sign-magnitude multiplier
//
// Accepts a command (start/len), streams len operand pairs into an external
// pipelined multiplier, accumulates the returned signed products with
// saturation, and presents the result on a valid/ready output.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, len                  command strobe (IDLE only), length (0 = 16)
//   in_valid/in_ready           operand-pair handshake
//   in_a, in_b, in_asign, in_bsign  operand magnitudes and sign bits
//   mul_a, mul_b, mul_asign, mul_bsign  registered drive to the multiplier
//   mul_m, mul_sign             product magnitude / sign from the multiplier
//   out_valid/out_ready         result handshake
//   out_acc, out_ovf            saturated signed result, saturation flag
//   busy                        high whenever not IDLE
module dot_seq #(
  parameter int ACC_W   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [3:0]              len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_a,
  input  logic [1:0]              in_b,
  input  logic                    in_asign,
  input  logic                    in_bsign,
  output logic [1:0]              mul_a,
  output logic [1:0]              mul_b,
  output logic                    mul_asign,
  output logic                    mul_bsign,
  input  logic [3:0]              mul_m,
  input  logic                    mul_sign,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic signed [ACC_W:0] MAX_S = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_S = {2'b11, {(ACC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [4:0]              len_q, len_d;
  logic [4:0]              issue_q, issue_d;
  logic [4:0]              done_q, done_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    in_ready_q, out_valid_q, busy_q;
  logic [1:0]              mul_a_q, mul_b_q;
  logic                    mul_asign_q, mul_bsign_q;
  // mul_v_q marks a pair on the multiplier inputs; tag_q follows it through
  // the multiplier pipeline so the product is sampled only when it is valid.
  logic                    mul_v_q;
  logic [MUL_LAT-1:0]      tag_q;

  logic                    accept, prod_v;
  logic signed [ACC_W:0]   term, sum;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    issue_d = issue_q;
    done_d  = done_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    accept = in_valid & in_ready_q;
    prod_v = tag_q[MUL_LAT-1];

    // A negative sign with zero magnitude negates to zero, so it adds nothing.
    term = {{(ACC_W-3){1'b0}}, mul_m};
    if (mul_sign) term = -term;
    sum = {acc_q[ACC_W-1], acc_q} + term;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          len_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          issue_d = 5'd0;
          done_d  = 5'd0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          issue_d = issue_q + 5'd1;
          if (issue_q + 5'd1 == len_q) state_d = DRAIN;
        end
      end
      DRAIN: ;
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Products return only after acceptance, so they land in RUN or DRAIN.
    if (prod_v && (state_q == RUN || state_q == DRAIN)) begin
      done_d = done_q + 5'd1;
      if (sum > MAX_S) begin
        acc_d = MAX_S[ACC_W-1:0];
        ovf_d = 1'b1;
      end else if (sum < MIN_S) begin
        acc_d = MIN_S[ACC_W-1:0];
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      if (state_q == DRAIN && done_q + 5'd1 == len_q) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= 5'd0;
      issue_q     <= 5'd0;
      done_q      <= 5'd0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= 2'd0;
      mul_b_q     <= 2'd0;
      mul_asign_q <= 1'b0;
      mul_bsign_q <= 1'b0;
      mul_v_q     <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_q     <= issue_d;
      done_q      <= done_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      // Handshake outputs are registered from the next state.
      in_ready_q  <= (state_d == RUN) && (issue_d < len_d);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      mul_a_q     <= accept ? in_a : 2'd0;
      mul_b_q     <= accept ? in_b : 2'd0;
      mul_asign_q <= accept & in_asign;
      mul_bsign_q <= accept & in_bsign;
      mul_v_q     <= accept;
      tag_q[0]    <= mul_v_q;
      for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_asign = mul_asign_q;
  assign mul_bsign = mul_bsign_q;

endmodule

// File: tb/tb_dot_seq.sv
// tb/tb_dot_seq.sv - self-checking bench for dot_seq
module tb_dot_seq;
  localparam int ACC_W   = 8;
  localparam int MUL_LAT = 1;

  logic clk, rst_n, start, in_valid, in_ready, in_asign, in_bsign;
  logic [3:0] len;
  logic [1:0] in_a, in_b, mul_a, mul_b;
  logic mul_asign, mul_bsign, mul_sign, out_valid, out_ready, out_ovf, busy;
  logic [3:0] mul_m;
  logic signed [ACC_W-1:0] out_acc;

  dot_seq #(.ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_asign(in_asign), .in_bsign(in_bsign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_asign(mul_asign), .mul_bsign(mul_bsign),
    .mul_m(mul_m), .mul_sign(mul_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined sign-magnitude multiplier model, MUL_LAT edges of latency.
  logic [4:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= {mul_asign ^ mul_bsign, {2'b00, mul_a} * {2'b00, mul_b}};
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign {mul_sign, mul_m} = mpipe[MUL_LAT-1];

  typedef struct packed {
    logic [3:0]        len;
    logic [4:0]        n;
    logic              gaps;
    logic [15:0][5:0]  pairs;
    logic signed [7:0] exp_acc;
    logic              exp_ovf;
  } vec_t;

  typedef struct packed {
    logic signed [7:0] acc;
    logic              ovf;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] mkp(input logic sa, input logic [1:0] a,
                                     input logic sb, input logic [1:0] b);
    return {sa, a, sb, b};
  endfunction

  // Independent reference: saturating signed accumulate of a*b terms.
  function automatic exp_t model(input vec_t v);
    int acc = 0;
    logic ovf = 1'b0;
    int t;
    for (int i = 0; i < v.n; i++) begin
      t = int'(v.pairs[i][4:3]) * int'(v.pairs[i][1:0]);
      acc = (v.pairs[i][5] ^ v.pairs[i][2]) ? acc - t : acc + t;
      if (acc > 127) begin acc = 127; ovf = 1'b1; end
      if (acc < -128) begin acc = -128; ovf = 1'b1; end
    end
    return '{acc[7:0], ovf};
  endfunction

  // Scoreboard: compare against the queue on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_acc", $signed(out_acc), $signed(e.acc));
        check("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  task automatic send_pair(input logic [5:0] p, output int acc_edge);
    bit ok = 0;
    {in_asign, in_a, in_bsign, in_b} = p;
    in_valid = 1'b1;
    acc_edge = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("in_ready_timeout", ok, 1);
    acc_edge = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mul_drive", {mul_asign, mul_a, mul_bsign, mul_b}, ok ? p : 6'd0);
  endtask

  task automatic start_cmd(input logic [3:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int acc_edge, input bit chk_lat);
    bit got = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    check("out_valid_timeout", got, 1);
    if (got && chk_lat) check("latency", cyc - acc_edge, MUL_LAT + 1);
  endtask

  task automatic run_vec(input vec_t v);
    int ae = 0;
    bit idle = 0;
    start_cmd(v.len);
    for (int i = 0; i < v.n; i++) begin
      if (v.gaps && i > 0) begin
        @(posedge clk); #1;
      end
      send_pair(v.pairs[i], ae);
    end
    sb_q.push_back('{v.exp_acc, v.exp_ovf});
    wait_valid(ae, 1'b1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!busy) begin idle = 1; break; end
    end
    check("back_to_idle", idle, 1);
  endtask

  vec_t vecs[8];

  initial begin
    int ae;
    exp_t m;
    // Vector table.
    for (int i = 0; i < 8; i++) vecs[i] = '0;
    vecs[0].len = 4'd1; vecs[0].n = 5'd1;
    vecs[0].pairs[0] = mkp(0, 3, 1, 3);
    vecs[0].exp_acc = -8'sd9; vecs[0].exp_ovf = 0;

    vecs[1].len = 4'd4; vecs[1].n = 5'd4; vecs[1].gaps = 1;
    vecs[1].pairs[0] = mkp(0, 2, 0, 3);
    vecs[1].pairs[1] = mkp(1, 1, 0, 1);
    vecs[1].pairs[2] = mkp(1, 0, 0, 3);
    vecs[1].pairs[3] = mkp(1, 3, 1, 3);
    vecs[1].exp_acc = 8'sd14; vecs[1].exp_ovf = 0;

    vecs[2].len = 4'd0; vecs[2].n = 5'd16;
    for (int j = 0; j < 16; j++) vecs[2].pairs[j] = mkp(0, 3, 0, 3);
    vecs[2].exp_acc = 8'sd127; vecs[2].exp_ovf = 1;

    vecs[3].len = 4'd0; vecs[3].n = 5'd16;
    for (int j = 0; j < 16; j++) vecs[3].pairs[j] = mkp(0, 3, 1, 3);
    vecs[3].exp_acc = -8'sd128; vecs[3].exp_ovf = 1;

    vecs[4].len = 4'd0; vecs[4].n = 5'd16;
    for (int j = 0; j < 15; j++) vecs[4].pairs[j] = mkp(0, 3, 0, 3);
    vecs[4].pairs[15] = mkp(1, 3, 0, 3);
    vecs[4].exp_acc = 8'sd118; vecs[4].exp_ovf = 1;

    vecs[5].len = 4'd2; vecs[5].n = 5'd2;
    vecs[5].pairs[0] = mkp(1, 2, 0, 0);
    vecs[5].pairs[1] = mkp(0, 1, 1, 1);
    vecs[5].exp_acc = -8'sd1; vecs[5].exp_ovf = 0;

    for (int k = 6; k < 8; k++) begin
      vecs[k].len = 4'($urandom_range(1, 15));
      vecs[k].n = {1'b0, vecs[k].len};
      vecs[k].gaps = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) vecs[k].pairs[j] = 6'($urandom);
      m = model(vecs[k]);
      vecs[k].exp_acc = m.acc;
      vecs[k].exp_ovf = m.ovf;
    end

    // Reset state.
    rst_n = 0; start = 0; len = 0; in_valid = 0; out_ready = 1;
    in_a = 0; in_b = 0; in_asign = 0; in_bsign = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_acc", $signed(out_acc), 0);
    check("rst_mul", {mul_asign, mul_a, mul_bsign, mul_b}, 0);
    rst_n = 1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Result held while out_ready is low; start is ignored in DONE.
    out_ready = 0;
    start_cmd(4'd1);
    send_pair(mkp(1, 2, 0, 3), ae);
    sb_q.push_back('{-8'sd6, 1'b0});
    wait_valid(ae, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1; len = 4'd2;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_acc", $signed(out_acc), -6);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("start_ignored_busy", busy, 0);
    check("after_hs_valid", out_valid, 0);

    // Asynchronous reset in the middle of a run.
    start_cmd(4'd4);
    send_pair(mkp(0, 3, 0, 3), ae);
    send_pair(mkp(0, 2, 0, 1), ae);
    @(posedge clk); #3;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_acc", $signed(out_acc), 9);
    rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_acc", $signed(out_acc), 0);
    check("arst_mul", {mul_asign, mul_a, mul_bsign, mul_b}, 0);
    check("arst_valid", out_valid, 0);
    @(posedge clk); #4;
    rst_n = 1;
    begin
      vec_t v;
      v = '0;
      v.len = 4'd1; v.n = 5'd1;
      v.pairs[0] = mkp(0, 1, 0, 2);
      v.exp_acc = 8'sd2; v.exp_ovf = 0;
      run_vec(v);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter ACC_W, default 8: signed accumulator/result width, two's complement, minimum 6.
REQ-002 Parameter MUL_LAT, default 1: clock edges from stable mul_* inputs to valid mul_m/mul_sign, range 1..4.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  command strobe; accepted only in IDLE.
REQ-006 len  input  4  vector length latched on accepted start; 0 encodes 16.
REQ-007 in_valid / in_ready  input / output  1 / 1  operand-pair handshake.
REQ-008 in_a, in_b  input  2 each  operand magnitudes; in_asign, in_bsign  input  1 each  sign bits (1 = negative).
REQ-009 mul_a, mul_b  output  2 each; mul_asign, mul_bsign  output  1 each  registered drive to the shared 2x2 sign-magnitude multiplier.
REQ-010 mul_m  input  4  product magnitude; mul_sign  input  1  product sign.
REQ-011 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 out_acc  output  ACC_W  signed dot-product result; out_ovf  output  1  saturation occurred.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE->RUN on start=1: latch len (0->16), clear accumulator, issue count and ovf.
REQ-016 in_ready=1 only in RUN while issue count < latched length; an operand pair is accepted on an edge with in_valid & in_ready.
REQ-017 An accepted pair is registered onto mul_a/mul_b/mul_asign/mul_bsign for exactly one cycle; in all other cycles mul_* are driven 0.
REQ-018 A valid-tag shift register of depth MUL_LAT tracks in-flight products; mul_m/mul_sign are sampled only when the tag emerges.
REQ-019 Signed term = mul_sign ? -mul_m : +mul_m; sign=1 with magnitude 0 adds 0.
REQ-020 Accumulation saturates at every step: a sum > 2^(ACC_W-1)-1 clamps to that value, a sum < -2^(ACC_W-1) clamps to that value; either case sets out_ovf (sticky until next start).
REQ-021 RUN->DRAIN on the edge accepting the last pair; DRAIN->DONE on the edge accumulating the last product.
REQ-022 out_valid rises exactly MUL_LAT+1 edges after the edge accepting the last pair; out_valid=1 only in DONE.
REQ-023 out_acc/out_ovf hold stable while out_valid=1; DONE->IDLE on out_valid & out_ready.
REQ-024 start is ignored in RUN, DRAIN, DONE, including the cycle of the out handshake.
REQ-025 Gaps in in_valid stall RUN indefinitely without affecting in-flight products.

Reset
REQ-026 rst_n=0 immediately forces IDLE; in_ready, out_valid, busy, out_ovf, mul_* = 0; out_acc = 0; tags, counters cleared.
REQ-027 Reset mid-RUN/DRAIN discards all in-flight products; the first start after release operates normally.

Verification
REQ-028 len=1, pair (3,+)x(3,-) -> out_acc=-9, out_ovf=0, out_valid MUL_LAT+1 edges after acceptance.
REQ-029 len=4, pairs (2,+)(3,+), (1,-)(1,+), (0,-)(3,+), (3,-)(3,-) with one-cycle in_valid gaps -> out_acc=14, out_ovf=0.
REQ-030 len=0, 16 pairs (3,+)(3,+) -> out_acc=127, out_ovf=1; all (3,+)(3,-) -> out_acc=-128, out_ovf=1.
REQ-031 len=0, 15 pairs (3,+)(3,+) then (3,-)(3,+) -> out_acc=118 (clamp before subtract), out_ovf=1.
REQ-032 out_ready low 5 cycles in DONE with start pulsed -> out_acc stable, start ignored, IDLE after handshake.
REQ-033 rst_n low for one cycle after 2 of 4 pairs accepted -> all outputs 0 asynchronously; new len=1 (1,+)(2,+) -> out_acc=2.
